// File: rtl/data_path.sv
// data_path: bus-based 32-bit CPU datapath driven one register-transfer step
// per clock by an external control unit.
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   *out                        bus drive enables (priority-muxed onto bus)
//   *in                         register load enables (capture on rising edge)
//   read, write                 memory strobes (read combinational, write at edge)
//   IncPc, control              ALU increment override and opcode
//   mdr_read                    MDR source: 00 bus, 01 memory, 10 Immediate, 11 zero
//   BAout, Rin, Rout, GRA/B/C   select-and-encode controls
//   Immediate, InportData       external data sources
//   *Val, *_D, ZVal*, ALUVal_*  observation of every register and the ALU
//   Rin_Select, Rout_Select     one-hot GPR load / drive enables
//   Branch                      CON flip-flop
module data_path (
  input  logic        clk,
  input  logic        reset,
  input  logic        CONin,
  input  logic [31:0] InportData,
  input  logic        PCout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        InPortout,
  input  logic        OutPortout,
  input  logic        Cout,
  input  logic        Zhighout,
  input  logic        MARin,
  input  logic        Zin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        InPortin,
  input  logic        OutPortin,
  input  logic        read,
  input  logic        write,
  input  logic        IncPc,
  input  logic [1:0]  mdr_read,
  input  logic [3:0]  control,
  input  logic        BAout,
  input  logic        Rin,
  input  logic        Rout,
  input  logic        GRA,
  input  logic        GRB,
  input  logic        GRC,
  input  logic [31:0] Immediate,
  output logic [31:0] R0Val,
  output logic [31:0] R1Val,
  output logic [31:0] R2Val,
  output logic [31:0] R3Val,
  output logic [31:0] R4Val,
  output logic [31:0] R5Val,
  output logic [31:0] R6Val,
  output logic [31:0] R7Val,
  output logic [31:0] R8Val,
  output logic [31:0] R9Val,
  output logic [31:0] R10Val,
  output logic [31:0] R11Val,
  output logic [31:0] R12Val,
  output logic [31:0] R13Val,
  output logic [31:0] R14Val,
  output logic [31:0] R15Val,
  output logic [31:0] IRval,
  output logic [31:0] MDRval,
  output logic [31:0] YVal,
  output logic [31:0] PCVal,
  output logic [31:0] MAR_D,
  output logic [31:0] InPort_D,
  output logic [31:0] OutPort_D,
  output logic [31:0] bus,
  output logic [31:0] mux_data_out,
  output logic [31:0] R0TempOut,
  output logic [31:0] C_sign_extended,
  output logic [31:0] mdatain,
  output logic [31:0] ZVal1,
  output logic [31:0] ZVal2,
  output logic [31:0] ALUVal_D1,
  output logic [31:0] ALUVal_D2,
  output logic [15:0] Rin_Select,
  output logic [15:0] Rout_Select,
  output logic        Branch
);

  localparam int unsigned W      = 32;
  localparam int unsigned NREG   = 16;
  localparam int unsigned AW     = 9;
  localparam int unsigned DEPTH  = 512;

  logic [W-1:0]  gpr [NREG];
  logic [W-1:0]  pc, ir, mar, mdr, y, z_lo, z_hi, hi, lo, in_port, out_port;
  logic          con;
  logic [W-1:0]  mem [DEPTH];

  logic [3:0]    sel_idx;
  logic          sel_any;
  logic [15:0]   sel_onehot;
  logic [W-1:0]  alu_lo, alu_hi;
  logic          con_d;

  // OutPortout is part of the control word but has no bus driver.
  logic unused_outportout;
  assign unused_outportout = OutPortout;

  // Select-and-encode: pick the IR register field, gate with Rin / Rout|BAout.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    if (GRA) begin
      sel_idx = ir[26:23];
      sel_any = 1'b1;
    end else if (GRB) begin
      sel_idx = ir[22:19];
      sel_any = 1'b1;
    end else if (GRC) begin
      sel_idx = ir[18:15];
      sel_any = 1'b1;
    end
    sel_onehot  = sel_any ? (16'd1 << sel_idx) : 16'd0;
    Rin_Select  = Rin ? sel_onehot : 16'd0;
    Rout_Select = (Rout || BAout) ? sel_onehot : 16'd0;
  end

  // R0 reads as zero in base-address mode.
  assign R0TempOut       = BAout ? '0 : gpr[0];
  assign C_sign_extended = {{13{ir[18]}}, ir[18:0]};
  assign mdatain         = read ? mem[mar[AW-1:0]] : '0;

  // Bus: priority mux, GPR drive first with the lowest index winning.
  always_comb begin
    bus = '0;
    if (|Rout_Select) begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (Rout_Select[i]) bus = (i == 0) ? R0TempOut : gpr[i];
      end
    end else if (HIout)     bus = hi;
    else if (LOout)         bus = lo;
    else if (Zhighout)      bus = z_hi;
    else if (Zlowout)       bus = z_lo;
    else if (PCout)         bus = pc;
    else if (MDRout)        bus = mdr;
    else if (InPortout)     bus = in_port;
    else if (Cout)          bus = C_sign_extended;
  end

  // MDR source mux.
  always_comb begin
    case (mdr_read)
      2'b00:   mux_data_out = bus;
      2'b01:   mux_data_out = mdatain;
      2'b10:   mux_data_out = Immediate;
      default: mux_data_out = '0;
    endcase
  end

  // ALU operand preparation: signed product and a trap-free signed divide.
  logic signed [63:0] a_ext, b_ext, prod;
  logic signed [W-1:0] div_den, quo, rem;
  logic [4:0] shamt;
  logic [W-1:0] ror_v, rol_v;
  always_comb begin
    a_ext = {{32{y[31]}}, y};
    b_ext = {{32{bus[31]}}, bus};
    prod  = a_ext * b_ext;
    // Min/-1 overflow divides by 1 instead, which gives the wrapped quotient.
    div_den = ((bus == '0) || ((y == 32'h8000_0000) && (bus == 32'hFFFF_FFFF)))
              ? 32'sd1 : $signed(bus);
    quo   = $signed(y) / div_den;
    rem   = $signed(y) % div_den;
    shamt = bus[4:0];
    ror_v = (y >> shamt) | (y << (6'd32 - 6'(shamt)));
    rol_v = (y << shamt) | (y >> (6'd32 - 6'(shamt)));
  end

  // ALU: A = Y, B = bus; high word only meaningful for MUL and DIV.
  always_comb begin
    alu_lo = bus;
    alu_hi = '0;
    if (IncPc) begin
      alu_lo = bus + 32'd1;
    end else begin
      case (control)
        4'd0:  alu_lo = y & bus;
        4'd1:  alu_lo = y | bus;
        4'd2:  alu_lo = y + bus;
        4'd3:  alu_lo = y - bus;
        4'd4:  {alu_hi, alu_lo} = prod;
        4'd5: begin
          if (bus == '0) begin
            alu_lo = '0;
          end else begin
            alu_lo = quo;
            alu_hi = rem;
          end
        end
        4'd6:  alu_lo = y >> shamt;
        4'd7:  alu_lo = 32'($signed(y) >>> shamt);
        4'd8:  alu_lo = y << shamt;
        4'd9:  alu_lo = ror_v;
        4'd10: alu_lo = rol_v;
        4'd11: alu_lo = -bus;
        4'd12: alu_lo = ~bus;
        default: alu_lo = bus;
      endcase
    end
  end

  // CON evaluation of the IR condition field against the bus.
  always_comb begin
    case (ir[20:19])
      2'b00:   con_d = (bus == '0);
      2'b01:   con_d = (bus != '0);
      2'b10:   con_d = ~bus[31];
      default: con_d = bus[31];
    endcase
  end

  // Register file and special registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      pc       <= '0;
      ir       <= '0;
      mar      <= '0;
      mdr      <= '0;
      y        <= '0;
      z_lo     <= '0;
      z_hi     <= '0;
      hi       <= '0;
      lo       <= '0;
      in_port  <= '0;
      out_port <= '0;
      con      <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (Rin_Select[i]) gpr[i] <= bus;
      end
      if (PCin)              pc       <= bus;
      if (IRin)              ir       <= bus;
      if (MARin)             mar      <= bus;
      if (MDRin)             mdr      <= mux_data_out;
      if (Yin)               y        <= bus;
      if (Zin || Zlowin)     z_lo     <= alu_lo;
      if (Zin || Zhighin)    z_hi     <= alu_hi;
      if (HIin)              hi       <= bus;
      if (LOin)              lo       <= bus;
      if (InPortin)          in_port  <= InportData;
      if (OutPortin)         out_port <= bus;
      if (CONin)             con      <= con_d;
    end
  end

  // Memory: no reset, contents loaded through the write port.
  always_ff @(posedge clk) begin
    if (write) mem[mar[AW-1:0]] <= mdr;
  end

  assign R0Val     = gpr[0];
  assign R1Val     = gpr[1];
  assign R2Val     = gpr[2];
  assign R3Val     = gpr[3];
  assign R4Val     = gpr[4];
  assign R5Val     = gpr[5];
  assign R6Val     = gpr[6];
  assign R7Val     = gpr[7];
  assign R8Val     = gpr[8];
  assign R9Val     = gpr[9];
  assign R10Val    = gpr[10];
  assign R11Val    = gpr[11];
  assign R12Val    = gpr[12];
  assign R13Val    = gpr[13];
  assign R14Val    = gpr[14];
  assign R15Val    = gpr[15];
  assign IRval     = ir;
  assign MDRval    = mdr;
  assign YVal      = y;
  assign PCVal     = pc;
  assign MAR_D     = mar;
  assign InPort_D  = in_port;
  assign OutPort_D = out_port;
  assign ZVal1     = z_lo;
  assign ZVal2     = z_hi;
  assign ALUVal_D1 = alu_lo;
  assign ALUVal_D2 = alu_hi;
  assign Branch    = con;

endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: behavioural model, per-cycle compare, directed
// program walk-through followed by randomized control words.
module tb_data_path;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, CONin;
  logic [31:0] InportData, Immediate;
  logic PCout, Zlowout, MDRout, HIout, LOout, InPortout, OutPortout, Cout, Zhighout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, InPortin, OutPortin;
  logic read, write, IncPc, BAout, Rin, Rout, GRA, GRB, GRC;
  logic [1:0] mdr_read;
  logic [3:0] control;

  logic [31:0] rv [16];
  logic [31:0] IRval, MDRval, YVal, PCVal, MAR_D, InPort_D, OutPort_D, bus, mux_data_out;
  logic [31:0] R0TempOut, C_sign_extended, mdatain, ZVal1, ZVal2, ALUVal_D1, ALUVal_D2;
  logic [15:0] Rin_Select, Rout_Select;
  logic Branch;

  data_path dut (
    .clk(clk), .reset(reset), .CONin(CONin), .InportData(InportData),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .InPortout(InPortout), .OutPortout(OutPortout), .Cout(Cout), .Zhighout(Zhighout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin), .InPortin(InPortin),
    .OutPortin(OutPortin), .read(read), .write(write), .IncPc(IncPc), .mdr_read(mdr_read),
    .control(control), .BAout(BAout), .Rin(Rin), .Rout(Rout), .GRA(GRA), .GRB(GRB),
    .GRC(GRC), .Immediate(Immediate),
    .R0Val(rv[0]), .R1Val(rv[1]), .R2Val(rv[2]), .R3Val(rv[3]), .R4Val(rv[4]),
    .R5Val(rv[5]), .R6Val(rv[6]), .R7Val(rv[7]), .R8Val(rv[8]), .R9Val(rv[9]),
    .R10Val(rv[10]), .R11Val(rv[11]), .R12Val(rv[12]), .R13Val(rv[13]),
    .R14Val(rv[14]), .R15Val(rv[15]),
    .IRval(IRval), .MDRval(MDRval), .YVal(YVal), .PCVal(PCVal), .MAR_D(MAR_D),
    .InPort_D(InPort_D), .OutPort_D(OutPort_D), .bus(bus), .mux_data_out(mux_data_out),
    .R0TempOut(R0TempOut), .C_sign_extended(C_sign_extended), .mdatain(mdatain),
    .ZVal1(ZVal1), .ZVal2(ZVal2), .ALUVal_D1(ALUVal_D1), .ALUVal_D2(ALUVal_D2),
    .Rin_Select(Rin_Select), .Rout_Select(Rout_Select), .Branch(Branch)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zlo, m_zhi, m_hi, m_lo, m_inp, m_outp;
  logic        m_con;
  logic [31:0] m_mem [512];
  bit          model_ok = 1'b0;

  function automatic int m_idx();
    if (GRA) return int'(m_ir[26:23]);
    if (GRB) return int'(m_ir[22:19]);
    if (GRC) return int'(m_ir[18:15]);
    return -1;
  endfunction

  function automatic logic [31:0] m_sext();
    return {{13{m_ir[18]}}, m_ir[18:0]};
  endfunction

  function automatic logic [15:0] m_rin_sel();
    int k = m_idx();
    return (k >= 0 && Rin) ? (16'd1 << k) : 16'd0;
  endfunction

  function automatic logic [15:0] m_rout_sel();
    int k = m_idx();
    return (k >= 0 && (Rout || BAout)) ? (16'd1 << k) : 16'd0;
  endfunction

  function automatic logic [31:0] m_bus();
    int k = m_idx();
    if (k >= 0 && (Rout || BAout)) return (k == 0) ? (BAout ? 32'd0 : m_r[0]) : m_r[k];
    if (HIout)     return m_hi;
    if (LOout)     return m_lo;
    if (Zhighout)  return m_zhi;
    if (Zlowout)   return m_zlo;
    if (PCout)     return m_pc;
    if (MDRout)    return m_mdr;
    if (InPortout) return m_inp;
    if (Cout)      return m_sext();
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_mdatain();
    return read ? m_mem[m_mar[8:0]] : 32'd0;
  endfunction

  function automatic logic [31:0] m_mux();
    case (mdr_read)
      2'd0: return m_bus();
      2'd1: return m_mdatain();
      2'd2: return Immediate;
      default: return 32'd0;
    endcase
  endfunction

  // Reference ALU in plain 64-bit integer arithmetic.
  function automatic logic [63:0] m_alu();
    logic [31:0] a, b;
    longint sa, sb, q, rm;
    int n;
    logic [63:0] dbl;
    a = m_y;
    b = m_bus();
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = int'(b[4:0]);
    dbl = {a, a};
    if (IncPc) return {32'd0, b + 32'd1};
    case (control)
      4'd0:  return {32'd0, a & b};
      4'd1:  return {32'd0, a | b};
      4'd2:  return {32'd0, a + b};
      4'd3:  return {32'd0, a - b};
      4'd4:  return 64'(sa * sb);
      4'd5: begin
        if (sb == 0) return 64'd0;
        q = sa / sb;
        rm = sa % sb;
        return {32'(rm), 32'(q)};
      end
      4'd6:  return {32'd0, a >> n};
      4'd7:  return {32'd0, 32'(sa >>> n)};
      4'd8:  return {32'd0, a << n};
      4'd9:  return {32'd0, 32'(dbl >> n)};
      4'd10: return {32'd0, 32'((dbl << n) >> 32)};
      4'd11: return {32'd0, 32'd0 - b};
      4'd12: return {32'd0, ~b};
      default: return {32'd0, b};
    endcase
  endfunction

  function automatic logic m_cond();
    logic [31:0] b = m_bus();
    case (m_ir[20:19])
      2'd0: return b == 32'd0;
      2'd1: return b != 32'd0;
      2'd2: return b[31] == 1'b0;
      default: return b[31] == 1'b1;
    endcase
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_step();
    logic [31:0] b, mx;
    logic [63:0] al;
    logic [15:0] rs;
    logic        cn;
    b = m_bus(); mx = m_mux(); al = m_alu(); rs = m_rin_sel(); cn = m_cond();
    if (write) m_mem[m_mar[8:0]] = m_mdr;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
      m_pc = 0; m_ir = 0; m_mar = 0; m_mdr = 0; m_y = 0; m_zlo = 0; m_zhi = 0;
      m_hi = 0; m_lo = 0; m_inp = 0; m_outp = 0; m_con = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) if (rs[i]) m_r[i] = b;
      if (PCin) m_pc = b;
      if (IRin) m_ir = b;
      if (MARin) m_mar = b;
      if (MDRin) m_mdr = mx;
      if (Yin) m_y = b;
      if (Zin || Zlowin) m_zlo = al[31:0];
      if (Zin || Zhighin) m_zhi = al[63:32];
      if (HIin) m_hi = b;
      if (LOin) m_lo = b;
      if (InPortin) m_inp = InportData;
      if (OutPortin) m_outp = b;
      if (CONin) m_con = cn;
    end
  endtask

  // Single compare process: registers and combinational outputs each cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      logic [63:0] al;
      al = m_alu();
      for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), rv[i], m_r[i]);
      chk("PC", PCVal, m_pc);
      chk("IR", IRval, m_ir);
      chk("MAR", MAR_D, m_mar);
      chk("MDR", MDRval, m_mdr);
      chk("Y", YVal, m_y);
      chk("Zlo", ZVal1, m_zlo);
      chk("Zhi", ZVal2, m_zhi);
      chk("InPort", InPort_D, m_inp);
      chk("OutPort", OutPort_D, m_outp);
      chk("Branch", {31'd0, Branch}, {31'd0, m_con});
      chk("bus", bus, m_bus());
      chk("mux", mux_data_out, m_mux());
      chk("mdatain", mdatain, m_mdatain());
      chk("R0Temp", R0TempOut, BAout ? 32'd0 : m_r[0]);
      chk("Csext", C_sign_extended, m_sext());
      chk("ALUlo", ALUVal_D1, al[31:0]);
      chk("ALUhi", ALUVal_D2, al[63:32]);
      chk("RinSel", {16'd0, Rin_Select}, {16'd0, m_rin_sel()});
      chk("RoutSel", {16'd0, Rout_Select}, {16'd0, m_rout_sel()});
    end
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    reset = 0; CONin = 0; PCout = 0; Zlowout = 0; MDRout = 0; HIout = 0; LOout = 0;
    InPortout = 0; OutPortout = 0; Cout = 0; Zhighout = 0; MARin = 0; Zin = 0; PCin = 0;
    MDRin = 0; IRin = 0; Yin = 0; HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0;
    InPortin = 0; OutPortin = 0; read = 0; write = 0; IncPc = 0; BAout = 0; Rin = 0;
    Rout = 0; GRA = 0; GRB = 0; GRC = 0; mdr_read = 0; control = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    model_ok = 1'b1;
    #1;
  endtask

  function automatic bit rb(input int unsigned one_in);
    return ($urandom % one_in) == 0;
  endfunction

  initial begin
    clr();
    Immediate = 0; InportData = 0;
    for (int i = 0; i < 512; i++) m_mem[i] = 32'd0;
    reset = 1; tick();

    // Load every memory word through MDR/MAR and the write strobe.
    for (int a = 0; a < 512; a++) begin
      clr(); Immediate = 32'(a); mdr_read = 2'd2; MDRin = 1; tick();
      clr(); MDRout = 1; MARin = 1; mdr_read = 2'd2; MDRin = 1;
      Immediate = (a == 16) ? 32'h0100_0005 : (a == 17) ? 32'h0100_0000 : $urandom;
      tick();
      clr(); write = 1; tick();
    end

    clr(); reset = 1; tick();
    // PC <- 16 via the Immediate path
    clr(); Immediate = 32'd16; mdr_read = 2'd2; MDRin = 1; tick();
    clr(); MDRout = 1; PCin = 1; tick();
    chk("lit_pc16", PCVal, 32'd16);
    // Fetch from address 16
    clr(); PCout = 1; MARin = 1; IncPc = 1; Zlowin = 1; tick();
    chk("lit_mar16", MAR_D, 32'd16);
    chk("lit_z17", ZVal1, 32'd17);
    clr(); Zlowout = 1; PCin = 1; read = 1; mdr_read = 2'd1; MDRin = 1; tick();
    chk("lit_pc17", PCVal, 32'd17);
    chk("lit_mdr_fetch", MDRval, 32'h0100_0005);
    clr(); MDRout = 1; IRin = 1; tick();
    chk("lit_ir", IRval, 32'h0100_0005);
    // ld-immediate style: R2 <- R0(BA) + C
    clr(); GRB = 1; BAout = 1; Yin = 1; tick();
    chk("lit_y0", YVal, 32'd0);
    clr(); Cout = 1; control = 4'd2; Zlowin = 1; tick();
    chk("lit_z5", ZVal1, 32'd5);
    clr(); Zlowout = 1; GRA = 1; Rin = 1; tick();
    chk("lit_r2", rv[2], 32'd5);
    // Fetch the out instruction at 17
    clr(); PCout = 1; MARin = 1; IncPc = 1; Zlowin = 1; tick();
    clr(); Zlowout = 1; PCin = 1; read = 1; mdr_read = 2'd1; MDRin = 1; tick();
    clr(); MDRout = 1; IRin = 1; tick();
    chk("lit_ir_out", IRval, 32'h0100_0000);
    clr(); GRA = 1; Rout = 1; OutPortin = 1;
    #1 chk("lit_routsel", {16'd0, Rout_Select}, 32'h0000_0004);
    tick();
    chk("lit_outport", OutPort_D, 32'd5);
    // Signed multiply 7 * -2
    clr(); Immediate = 32'd7; mdr_read = 2'd2; MDRin = 1; tick();
    clr(); MDRout = 1; Yin = 1; Immediate = 32'hFFFF_FFFE; mdr_read = 2'd2; MDRin = 1; tick();
    clr(); MDRout = 1; control = 4'd4; Zin = 1; tick();
    chk("lit_mul_hi", ZVal2, 32'hFFFF_FFFF);
    chk("lit_mul_lo", ZVal1, 32'hFFFF_FFF2);
    // CON with bus = 0 and condition 00
    clr(); CONin = 1; tick();
    chk("lit_branch", {31'd0, Branch}, 32'd1);
    // Reset mid-sequence
    clr(); reset = 1; tick();
    chk("lit_rst_pc", PCVal, 32'd0);
    chk("lit_rst_r2", rv[2], 32'd0);
    chk("lit_rst_out", OutPort_D, 32'd0);
    chk("lit_rst_zhi", ZVal2, 32'd0);
    chk("lit_rst_ir", IRval, 32'd0);
    chk("lit_rst_br", {31'd0, Branch}, 32'd0);
    // Memory survives reset
    clr(); Immediate = 32'd16; mdr_read = 2'd2; MDRin = 1; tick();
    clr(); MDRout = 1; MARin = 1; tick();
    clr(); read = 1;
    #1 chk("lit_mem_keep", mdatain, 32'h0100_0005);
    tick();

    // Randomized control words
    for (int c = 0; c < 4000; c++) begin
      clr();
      reset = rb(80);
      PCout = rb(8); Zlowout = rb(8); MDRout = rb(8); HIout = rb(10); LOout = rb(10);
      InPortout = rb(10); OutPortout = rb(6); Cout = rb(8); Zhighout = rb(10);
      MARin = rb(4); Zin = rb(4); PCin = rb(5); MDRin = rb(3); IRin = rb(4); Yin = rb(3);
      HIin = rb(5); LOin = rb(5); Zhighin = rb(5); Zlowin = rb(5); InPortin = rb(4);
      OutPortin = rb(4); read = rb(2); write = rb(6); IncPc = rb(8); CONin = rb(3);
      BAout = rb(6); Rin = rb(3); Rout = rb(3); GRA = rb(3); GRB = rb(3); GRC = rb(3);
      mdr_read = 2'($urandom); control = 4'($urandom);
      Immediate = rb(8) ? 32'($urandom_range(0, 40)) : $urandom;
      InportData = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
